// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   subState_e    : FSM state encoding (S_IDLE, S_RUN, S_DONE)
//   SUB_WIDTH_DEF : default operand/result width
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } subState_e;

    localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_sub_fs.sv
// -----------------------------------------------------------------------------
// serial_sub_fs
// Purely combinational one-bit full subtractor: d = a - b - bin.
// Ports:
//   a    in  : minuend bit
//   b    in  : subtrahend bit
//   bin  in  : borrow in
//   d    out : difference bit
//   bout out : borrow out
// -----------------------------------------------------------------------------
module serial_sub_fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d = a ^ b ^ bin;

    // A borrow is needed when b exceeds a, or when they are equal and a
    // borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
// Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, LSB first,
// one bit per clock using a single full-subtractor cell and a borrow flop.
// A start/done handshake frames each operation (WIDTH+2 cycles per op).
//
// Ports:
//   clk   in  : clock, rising edge
//   rst   in  : synchronous active-high reset
//   start in  : request, accepted only in IDLE
//   a     in  : minuend, sampled on the accepting edge
//   b     in  : subtrahend, sampled on the accepting edge
//   bin   in  : borrow-in, sampled on the accepting edge
//   busy  out : high while bits are processed
//   done  out : one-cycle pulse, results valid
//   diff  out : result, held until the next accepted start
//   bout  out : borrow-out (unsigned wrap)
//   ovf   out : signed overflow (only with SERIAL_SUB_OVF_EN)
//
// Configuration macro: SERIAL_SUB_OVF_EN adds the ovf port and its flops.
// -----------------------------------------------------------------------------
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    subState_e        state_q, state_d;
    logic [WIDTH-1:0] aShift_q;
    logic [WIDTH-1:0] bShift_q;
    logic [WIDTH-2:0] res_q;
    logic             borrow_q;
    logic [CNT_W-1:0] bitCnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             aMsb_q;
    logic             bMsb_q;
    logic             ovf_q;
`endif

    logic             fsD;
    logic             fsBout;
    logic             lastBit;
    logic [WIDTH-1:0] resNext;

    serial_sub_fs uFs (
        .a    (aShift_q[0]),
        .b    (bShift_q[0]),
        .bin  (borrow_q),
        .d    (fsD),
        .bout (fsBout)
    );

    assign lastBit = (bitCnt_q == CNT_W'(WIDTH - 1));

    // Only WIDTH-1 bits are stored between edges; on the final edge the
    // fresh MSB joins them to form the complete result.
    assign resNext = {fsD, res_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start)   state_d = S_RUN;
            S_RUN:  if (lastBit) state_d = S_DONE;
            S_DONE:              state_d = S_IDLE;
            default:             state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aShift_q <= '0;
            bShift_q <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            bitCnt_q <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            aMsb_q   <= 1'b0;
            bMsb_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        aShift_q <= a;
                        bShift_q <= b;
                        borrow_q <= bin;
                        bitCnt_q <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        aMsb_q   <= a[WIDTH-1];
                        bMsb_q   <= b[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    res_q    <= resNext[WIDTH-1:1];
                    aShift_q <= {1'b0, aShift_q[WIDTH-1:1]};
                    bShift_q <= {1'b0, bShift_q[WIDTH-1:1]};
                    borrow_q <= fsBout;
                    bitCnt_q <= bitCnt_q + 1'b1;
                    if (lastBit) begin
                        diff_q <= resNext;
                        bout_q <= fsBout;
`ifdef SERIAL_SUB_OVF_EN
                        // fsD is the result MSB on the final bit.
                        ovf_q  <= (aMsb_q != bMsb_q) && (fsD != aMsb_q);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_sub
// Self-checking bench for serial_sub (WIDTH=8). A driver issues directed and
// random operations and pushes the arithmetically computed expectation into
// a queue when it knows the DUT accepts; a monitor pops and compares on done.
// -----------------------------------------------------------------------------
module tb_serial_sub;

    localparam int W = 8;
    localparam int PERIOD = W + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           doneCycle;
    } expect_t;

    expect_t expQ[$];
    int      tests = 0;
    int      fails = 0;
    int      cycleCnt = 0;
    int      nextAccept = 0;
    int      busyRun = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic expect_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                      input logic bi, input int acceptEdge);
        expect_t e;
        int raw;
        int sa;
        int sb;
        int sres;
        raw = int'(aa) - int'(bb) - int'(bi);
        e.diff = raw[W-1:0];
        e.bout = (raw < 0);
        sa = aa[W-1] ? int'(aa) - (1 << W) : int'(aa);
        sb = bb[W-1] ? int'(bb) - (1 << W) : int'(bb);
        sres = sa - sb - int'(bi);
        e.ovf = (sres < -(1 << (W - 1))) || (sres > (1 << (W - 1)) - 1);
        e.doneCycle = acceptEdge + W;
        return e;
    endfunction

    // Drive inputs for the coming edge (call at a negedge) and record the
    // expectation if the protocol says this edge accepts.
    task automatic driveNow(input logic s, input logic [W-1:0] aa,
                            input logic [W-1:0] bb, input logic bi);
        start = s;
        a     = aa;
        b     = bb;
        bin   = bi;
        if (s && !rst && (cycleCnt + 1 >= nextAccept)) begin
            expQ.push_back(model(aa, bb, bi, cycleCnt + 1));
            nextAccept = cycleCnt + 1 + PERIOD;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [W-1:0] aa,
                                 input logic [W-1:0] bb, input logic bi);
        @(negedge clk);
        driveNow(s, aa, bb, bi);
    endtask

    task automatic idleRandom();
        applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    // Wait for the DUT to be ready, issue one op, then scramble the inputs.
    task automatic doOp(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
        while (cycleCnt + 1 < nextAccept) idleRandom();
        applyStimulus(1'b1, aa, bb, bi);
        idleRandom();
    endtask

    // One reset edge, then check reset values; leaves rst released at a negedge.
    task automatic resetPulse();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_diff", 32'(diff), 32'd0);
        checkOutput("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        nextAccept = cycleCnt + 1;
    endtask

    // Monitor: compare each done pulse with the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            checkOutput("busy_in_done", 32'(busy), 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                expect_t e;
                e = expQ.pop_front();
                checkOutput("diff", 32'(diff), 32'(e.diff));
                checkOutput("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
                checkOutput("done_cycle", 32'(cycleCnt), 32'(e.doneCycle));
                checkOutput("busy_cycles", 32'(busyRun), 32'(W));
            end
            busyRun = 0;
        end else if (busy === 1'b1) begin
            busyRun++;
        end else begin
            busyRun = 0;
        end
    end

    initial begin
        resetPulse();

        // Directed cases
        doOp(8'h37, 8'h12, 1'b0);
        doOp(8'h00, 8'h01, 1'b0);
        doOp(8'h10, 8'h0F, 1'b1);
        doOp(8'h05, 8'h05, 1'b1);
        doOp(8'h80, 8'h01, 1'b0);
        doOp(8'h7F, 8'hFF, 1'b0);
        doOp(8'hFF, 8'hFF, 1'b1);
        doOp(8'h00, 8'h00, 1'b0);

        // start held high with operands changing every cycle
        while (cycleCnt + 1 < nextAccept) idleRandom();
        for (int i = 0; i < 6 * PERIOD; i++) begin
            applyStimulus(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        end
        idleRandom();

        // Abort in the third RUN cycle, then start right after release
        doOp(W'($urandom), W'($urandom), 1'($urandom));
        idleRandom();
        resetPulse();
        driveNow(1'b1, 8'h37, 8'h12, 1'b0);
        idleRandom();

        // Random traffic with sporadic start
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom),
                          1'($urandom));
        end

        // Drain outstanding results within a bounded window
        for (int i = 0; i < 4 * PERIOD && expQ.size() > 0; i++) idleRandom();
        if (expQ.size() > 0) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial N-bit subtractor computing diff = a − b − bin one bit per clock, LSB first, with a single borrow flip-flop. It is the subtracting counterpart to the team's combinational full adder and sits in the datapath wherever area matters more than latency. A start/done handshake frames each operation. The core is one combinational full-subtractor bit iterated over time.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥ 2)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  request; accepted only in IDLE
- a  input  WIDTH  minuend, sampled on the accepting edge only
- b  input  WIDTH  subtrahend, sampled on the accepting edge only
- bin  input  1  borrow-in, sampled on the accepting edge only
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse; diff/bout/ovf valid
- diff  output  WIDTH  result, held until the next accepted start
- bout  output  1  borrow-out (1 ⇔ a < b + bin, unsigned)
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → load a/b shift registers, borrow reg ← bin, bit counter ← 0, state → RUN. start=0 → stay.
- RUN: each edge processes LSB of the shift registers: d = a0 ^ b0 ^ br; br ← (~a0 & b0) | (~(a0 ^ b0) & br); d shifted into the MSB of the result register; operands shift right; counter +1.
- When the counter reaches WIDTH−1 on an edge, that edge also transfers the result register into diff, br into bout, and state → DONE.
- DONE: done=1 for exactly one cycle; next edge → IDLE unconditionally.
- start in RUN or DONE is ignored (not queued). Input changes after the accepting edge have no effect.
- Arithmetic is modulo 2^WIDTH. bout = 1 exactly when the unsigned result wrapped.

## Timing
- Reset values: state IDLE, busy 0, done 0, diff 0, bout 0, ovf 0, all internal registers 0.
- If start is accepted at edge k, bits are processed on edges k+1 … k+WIDTH.
- diff and bout update at edge k+WIDTH, and done is high in the cycle following it.
- The earliest next acceptance is edge k+WIDTH+2, so throughput is one op per WIDTH+2 cycles with start held high.
- busy is high from after edge k through edge k+WIDTH, and low in DONE.
- rst has priority over every other input.
- Reset asserted mid-RUN or in DONE aborts the operation: there is no done pulse and outputs return to reset values at that edge.
- A start accepted in the first cycle after reset release behaves normally.

## Configuration
- SERIAL_SUB_OVF_EN defined: the ovf port exists.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from a[MSB] and b[MSB] captured at start.
  - ovf is registered together with diff and holds until the next start.
  - bin is not included in the overflow term beyond its effect on diff.
- SERIAL_SUB_OVF_EN undefined: the ovf port and its capture flops are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - default width constant SUB_WIDTH_DEF=8.
- One sub-module, fs: a purely combinational full subtractor with inputs a, b, bin and outputs d, bout. It is instantiated once and iterated serially.
- The counter is $clog2(WIDTH) bits wide.

## Test plan
- WIDTH=8, a=0x37, b=0x12, bin=0, start at edge k → done in cycle after edge k+8, diff=0x25, bout=0, busy high 8 cycles.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1; with OVF_EN, ovf=0.
- a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0. Then a=0x05, b=0x05, bin=1 → diff=0xFF, bout=1.
- OVF_EN: a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- Hold start=1 continuously with changing a/b → only operands present at each IDLE acceptance are used; done pulses every 10 cycles; mid-RUN operand changes have no effect.
- rst at third RUN cycle → next cycle: IDLE, diff=0, bout=0, no done. A subsequent start of 0x37−0x12 yields 0x25.
